// File: rtl/mant_pkg.sv
// Shared types and rounding helper for the mantissa
// normalize/round pipeline.
package mant_pkg;

  localparam int MANT_W = 11;
  localparam int EXP_W  = 5;
  localparam int PWIDTH = 2*MANT_W;
  localparam int XWIDTH = EXP_W+1;

  typedef struct packed {
    logic [MANT_W-1:0] m;
    logic              g;
    logic              s;
    logic [XWIDTH-1:0] e;
    logic              zero;
  } norm_t;

  typedef struct packed {
    logic [MANT_W-1:0] mant;
    logic [XWIDTH-1:0] exp;
    logic              zero;
    logic              ovf;
    logic              inexact;
  } res_t;

  // Round-to-nearest-even; a carry-out renormalizes to 1.0
  function automatic res_t rne_round(input norm_t n);
    logic          up;
    logic [MANT_W:0] r;
    res_t          o;
    up = n.g & (n.s | n.m[0]);
    r  = {1'b0, n.m} + {{MANT_W{1'b0}}, up};
    o.zero = n.zero;
    if (r[MANT_W]) begin
      o.mant = {1'b1, {(MANT_W-1){1'b0}}};
      o.exp  = n.e + XWIDTH'(1);
    end else begin
      o.mant = r[MANT_W-1:0];
      o.exp  = n.e;
    end
    o.inexact = (n.g | n.s) & ~n.zero;
    o.ovf     = (o.exp >= XWIDTH'((1 << EXP_W) - 1))
              & ~n.zero;
    return o;
  endfunction

endpackage

// File: rtl/mant_normalizer.sv
// Combinational stage 1: align the 2.x product to 1.x
// and extract guard/sticky.
module mant_normalizer
  import mant_pkg::*;
(
  input  logic [PWIDTH-1:0] prod,
  input  logic [XWIDTH-1:0] exp_sum,
  output norm_t             norm
);

  always_comb begin
    norm = '0;
    if (prod == '0) begin
      norm.zero = 1'b1;
    end else if (prod[PWIDTH-1]) begin
      norm.m = prod[PWIDTH-1:MANT_W];
      norm.g = prod[MANT_W-1];
      norm.s = |prod[MANT_W-2:0];
      norm.e = exp_sum + XWIDTH'(1);
    end else begin
      norm.m = prod[PWIDTH-2:MANT_W-1];
      norm.g = prod[MANT_W-2];
      norm.s = |prod[MANT_W-3:0];
      norm.e = exp_sum;
    end
  end

endmodule

// File: rtl/mant_norm_round.sv
// Two-stage elastic pipeline: normalize, then round
// to nearest even and adjust the exponent.
module mant_norm_round
  import mant_pkg::*;
#(
  parameter int DWIDTH = MANT_W,
  parameter int EWIDTH = EXP_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DWIDTH-1:0] prod_i,
  input  logic [EWIDTH:0]     exp_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DWIDTH-1:0]   mant_o,
  output logic [EWIDTH:0]     exp_o,
  output logic                zero_o,
  output logic                ovf_o,
  output logic                inexact_o
);

  norm_t norm;
  norm_t s1;
  res_t  s2;
  logic  s1_valid;
  logic  s2_valid;
  logic  s1_adv;
  logic  s2_adv;

  mant_normalizer u_norm (
    .prod    (prod_i),
    .exp_sum (exp_i),
    .norm    (norm)
  );

  assign s2_adv   = out_ready | ~s2_valid;
  assign s1_adv   = s2_adv | ~s1_valid;
  assign in_ready = s1_adv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) s1 <= norm;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2 <= rne_round(s1);
      end
    end
  end

  assign out_valid = s2_valid;
  assign mant_o    = s2.mant;
  assign exp_o     = s2.exp;
  assign zero_o    = s2.zero;
  assign ovf_o     = s2.ovf;
  assign inexact_o = s2.inexact;

endmodule

// File: tb/tb_mant_norm_round.sv
// Bench for mant_norm_round: directed table, stall and
// reset sequences, random traffic against a model.
module tb_mant_norm_round;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [21:0] prod_i;
  logic [5:0]  exp_i;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] mant_o;
  logic [5:0]  exp_o;
  logic        zero_o;
  logic        ovf_o;
  logic        inexact_o;

  mant_norm_round #(.DWIDTH(11), .EWIDTH(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod_i    (prod_i),
    .exp_i     (exp_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mant_o    (mant_o),
    .exp_o     (exp_o),
    .zero_o    (zero_o),
    .ovf_o     (ovf_o),
    .inexact_o (inexact_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] prod;
    logic [5:0]  ei;
    logic [10:0] mant;
    logic [5:0]  eo;
    logic        z;
    logic        o;
    logic        x;
  } vec_t;

  typedef struct {
    logic [10:0] mant;
    logic [5:0]  eo;
    logic        z;
    logic        o;
    logic        x;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   en_mon = 1'b0;
  exp_t sb[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Reference: shift out the low bits, round on the
  // exact remainder against half an ulp.
  function automatic exp_t model(input logic [21:0] p,
                                 input logic [5:0] e);
    exp_t r;
    int   pv, sh, m, rem, half, ee;
    pv = int'(p);
    if (pv == 0) begin
      r = '{11'd0, 6'd0, 1'b1, 1'b0, 1'b0};
      return r;
    end
    sh   = (pv >= (1 << 21)) ? 11 : 10;
    ee   = int'(e) + sh - 10;
    m    = pv >> sh;
    rem  = pv % (1 << sh);
    half = 1 << (sh - 1);
    if (rem > half || (rem == half && m % 2 == 1)) m++;
    if (m == 2048) begin
      m = 1024;
      ee++;
    end
    ee     = ee % 64;
    r.mant = 11'(m);
    r.eo   = 6'(ee);
    r.z    = 1'b0;
    r.o    = (ee >= 31);
    r.x    = (rem != 0);
    return r;
  endfunction

  task automatic chk_out(input string tag, input exp_t x);
    chk({tag, "_mant"}, 32'(mant_o), 32'(x.mant));
    chk({tag, "_exp"}, 32'(exp_o), 32'(x.eo));
    chk({tag, "_zero"}, 32'(zero_o), 32'(x.z));
    chk({tag, "_ovf"}, 32'(ovf_o), 32'(x.o));
    chk({tag, "_inexact"}, 32'(inexact_o), 32'(x.x));
  endtask

  always @(negedge clk) begin
    if (en_mon && rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          chk_out("rand", sb.pop_front());
        end
      end
      if (in_valid && in_ready) sb.push_back(model(prod_i, exp_i));
    end
  end

  task automatic send_one(input string tag,
                          input logic [21:0] p,
                          input logic [5:0] e,
                          input exp_t x);
    int cyc;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    prod_i    = p;
    exp_i     = e;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd1);
    chk_out(tag, x);
  endtask

  vec_t tbl[9];
  exp_t xa, xb, xc;

  initial begin
    tbl[0] = '{22'h100000, 6'd15, 11'h400, 6'd15, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{22'h3FF001, 6'd15, 11'h7FE, 6'd16, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{22'h1FFE00, 6'd10, 11'h400, 6'd11, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{22'h100200, 6'd10, 11'h400, 6'd10, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{22'h100600, 6'd10, 11'h402, 6'd10, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{22'h200000, 6'd30, 11'h400, 6'd31, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{22'h000000, 6'd20, 11'h000, 6'd0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{22'h3FFFFF, 6'd5, 11'h400, 6'd7, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{22'h300C00, 6'd29, 11'h602, 6'd30, 1'b0, 1'b0, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    prod_i    = '0;
    exp_i     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk_out("rst", '{11'd0, 6'd0, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 9; i++) begin
      send_one($sformatf("tbl%0d", i), tbl[i].prod, tbl[i].ei,
               '{tbl[i].mant, tbl[i].eo, tbl[i].z,
                 tbl[i].o, tbl[i].x});
    end

    // Backpressure: two accepted, third blocked
    @(posedge clk); #1;
    xa = model(22'h3FF001, 6'd15);
    xb = model(22'h100600, 6'd10);
    xc = model(22'h200000, 6'd30);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    prod_i    = 22'h3FF001;
    exp_i     = 6'd15;
    chk("bp_rdy1", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    prod_i = 22'h100600;
    exp_i  = 6'd10;
    chk("bp_rdy2", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    prod_i = 22'h200000;
    exp_i  = 6'd30;
    chk("bp_rdy3", 32'(in_ready), 32'd0);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk_out("bp_a", xa);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_hold_rdy", 32'(in_ready), 32'd0);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk_out("bp_hold", xa);
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_b_valid", 32'(out_valid), 32'd1);
    chk_out("bp_b", xb);
    @(posedge clk); #1;
    chk("bp_c_valid", 32'(out_valid), 32'd1);
    chk_out("bp_c", xc);
    @(posedge clk); #1;
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Reset with the pipeline full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    prod_i    = 22'h3FFFFF;
    exp_i     = 6'd9;
    repeat (2) @(posedge clk);
    #1;
    chk("full_valid", 32'(out_valid), 32'd1);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk_out("mid_rst", '{11'd0, 6'd0, 1'b0, 1'b0, 1'b0});
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_quiet", 32'(out_valid), 32'd0);
    send_one("post_rst", 22'h1FFE00, 6'd3,
             '{11'h400, 6'd4, 1'b0, 1'b0, 1'b1});
    @(posedge clk); #1;

    // Random traffic, including simultaneous accept/drain
    en_mon = 1'b1;
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 7))
        0:       prod_i = '0;
        1:       prod_i = 22'($urandom_range(1, 3)) << 20;
        2:       prod_i = 22'h200000 | 22'($urandom) & 22'h3FFC00
                        | 22'h000400;
        default: prod_i = 22'($urandom);
      endcase
      exp_i = 6'($urandom_range(0, 60));
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && sb.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    en_mon = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
